// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared size codes, FSM state encoding and byte-enable helper for rv_data_mem
package rv_mem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    return size == SIZE_B ? 4'b0001 << lane :
           size == SIZE_H ? (lane[1] ? 4'b1100 : 4'b0011) :
           size == SIZE_W ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/rv_load_align.sv
// rv_load_align: steers a byte/half out of a memory word and sign- or zero-extends it
module rv_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    data = size == SIZE_B ? {{24{b[7] & ~zext}}, b} :
           size == SIZE_H ? {{16{h[15] & ~zext}}, h} : word;
  end
endmodule

// File: rtl/rv_data_mem.sv
// rv_data_mem: byte-addressed RV32 memory with req/rsp handshake, wait states and lane steering
module rv_data_mem
  import rv_mem_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_BYTES = 'h0100000,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h01000000,
  parameter int                WAIT_CYCLES = 0,
  parameter string             INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(DEPTH_BYTES);

  state_t state;
  logic [3:0] cnt;
  logic wr_q, uns_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q;

  logic in_idle, cur_wr, cur_uns, commit, err, we;
  logic [1:0] cur_size, lane;
  logic [ADDR_W-1:0] cur_addr, off;
  logic [ADDR_W:0] end_off;
  logic [31:0] cur_wdata, wdata_rep, word, load_data;
  logic [3:0] be;
  logic [AW-3:0] widx;

  logic [7:0] mem [DEPTH_BYTES];

  // In IDLE the live request is used directly so a zero-wait access commits on its acceptance edge
  always_comb begin
    in_idle = state == IDLE;
    cur_wr = in_idle ? req_write : wr_q;
    cur_uns = in_idle ? req_unsigned : uns_q;
    cur_size = in_idle ? req_size : size_q;
    cur_addr = in_idle ? req_addr : addr_q;
    cur_wdata = in_idle ? req_wdata : wdata_q;
    off = cur_addr - BASE_ADDR;
    lane = off[1:0];
    widx = off[AW-1:2];
    end_off = {1'b0, off} + ((ADDR_W+1)'(1) << cur_size);
    err = cur_size == 2'b11 || end_off > DEPTH ||
          (cur_size == SIZE_H && off[0]) || (cur_size == SIZE_W && lane != 2'b00);
    commit = (in_idle && req_valid && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
    we = commit && reset_n && cur_wr && !err;
    be = byte_en(cur_size, lane);
    wdata_rep = cur_size == SIZE_B ? {4{cur_wdata[7:0]}} :
                cur_size == SIZE_H ? {2{cur_wdata[15:0]}} : cur_wdata;
    word = {mem[{widx, 2'd3}], mem[{widx, 2'd2}], mem[{widx, 2'd1}], mem[{widx, 2'd0}]};
  end

  rv_load_align u_align (
    .word (word),
    .lane (lane),
    .size (cur_size),
    .zext (cur_uns),
    .data (load_data)
  );

  always @(posedge clock)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[{widx, 2'(i)}] <= wdata_rep[8*i +: 8];

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      wr_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= SIZE_B;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      if (commit) begin
        state <= RESP;
        req_ready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err <= err;
        rsp_rdata <= (err || cur_wr) ? '0 : load_data;
      end
      case (state)
        IDLE: if (req_valid) begin
          wr_q <= req_write;
          uns_q <= req_unsigned;
          size_q <= req_size;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          req_ready <= 1'b0;
          if (WAIT_CYCLES != 0) begin
            state <= WAIT;
            cnt <= 4'(WAIT_CYCLES - 1);
          end
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        RESP: if (rsp_ready) begin
          state <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rv_data_mem.sv
// tb_rv_data_mem: randomized bench for rv_data_mem (zero-wait and 3-wait instances) against a byte-array model
module tb_rv_data_mem;
  import rv_mem_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int DEPTH = 'h1000;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic req_valid [2], req_ready [2], req_write [2], req_unsigned [2];
  logic rsp_valid [2], rsp_ready [2], rsp_err [2];
  logic [1:0] req_size [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  logic [7:0] mdl [2][DEPTH];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rv_data_mem #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) d0 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  rv_data_mem #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) d1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain byte-array arithmetic, little-endian, with range/alignment rules
  task automatic model(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er);
    logic [31:0] o32;
    longint off, v;
    int n, idx;
    o32 = addr - BASE;
    off = longint'(o32);
    n = 1 << sz;
    er = sz == 2'b11 || off + n > DEPTH || off % n != 0;
    rd = '0;
    if (er) return;
    idx = int'(off);
    if (wr) begin
      for (int k = 0; k < n; k++) mdl[d][idx+k] = wd[8*k +: 8];
    end else begin
      v = 0;
      for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(mdl[d][idx+k]);
      if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
      rd = 32'(v);
    end
  endtask

  task automatic xact(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int stall,
                      output logic [31:0] rd, output bit er);
    logic [31:0] erd;
    bit eer;
    int lat;
    model(d, wr, sz, uns, addr, wd, erd, eer);
    @(negedge clock);
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_size[d] = sz;
    req_unsigned[d] = uns;
    req_addr[d] = addr;
    req_wdata[d] = wd;
    @(posedge clock);
    #1;
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_size[d] = 2'($urandom);
    req_unsigned[d] = 1'($urandom);
    req_addr[d] = $urandom;
    req_wdata[d] = $urandom;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), d == 0 ? 32'd1 : 32'd4);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    chk("rdata", rd, erd);
    chk("err", 32'(er), 32'(eer));
    for (int i = 0; i < stall; i++) begin
      @(posedge clock);
      #1;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], rd);
      chk("hold_err", 32'(rsp_err[d]), 32'(er));
      chk("busy_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready[d] = 1'b0;
    chk("rsp_drop", 32'(rsp_valid[d]), 32'd0);
    chk("ready_back", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic dir(input string tag, input int d, input bit wr, input logic [1:0] sz,
                     input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                     input int stall, input logic [31:0] erd, input bit eer);
    logic [31:0] rd;
    bit er;
    xact(d, wr, sz, uns, addr, wd, stall, rd, er);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, 32'(er), 32'(eer));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, rd;
    bit er;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_size[d] = SIZE_B;
      req_unsigned[d] = 1'b0;
      req_addr[d] = '0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b0;
    end
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'd0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    dir("sw_init", 0, 1, SIZE_W, 0, BASE, 32'hABCD8765, 0, 32'h0, 0);
    dir("lhu", 0, 0, SIZE_H, 1, BASE + 2, 32'h0, 0, 32'h0000ABCD, 0);
    dir("lh", 0, 0, SIZE_H, 0, BASE + 2, 32'h0, 0, 32'hFFFFABCD, 0);
    dir("lb", 0, 0, SIZE_B, 0, BASE + 1, 32'h0, 0, 32'hFFFFFF87, 0);
    dir("lbu", 0, 0, SIZE_B, 1, BASE + 1, 32'h0, 0, 32'h00000087, 0);
    dir("sb", 0, 1, SIZE_B, 0, BASE + 3, 32'h00000011, 0, 32'h0, 0);
    dir("lw_sb", 0, 0, SIZE_W, 0, BASE, 32'h0, 0, 32'h11CD8765, 0);
    dir("sh", 0, 1, SIZE_H, 0, BASE, 32'h00002222, 0, 32'h0, 0);
    dir("lw_sh", 0, 0, SIZE_W, 0, BASE, 32'h0, 0, 32'h11CD2222, 0);
    dir("lw_mis", 0, 0, SIZE_W, 0, BASE + 2, 32'h0, 0, 32'h0, 1);
    dir("sh_mis", 0, 1, SIZE_H, 0, BASE + 1, 32'h00005555, 0, 32'h0, 1);
    dir("lw_keep", 0, 0, SIZE_W, 0, BASE, 32'h0, 0, 32'h11CD2222, 0);
    dir("lw_below", 0, 0, SIZE_W, 0, BASE - 4, 32'h0, 0, 32'h0, 1);
    dir("lw_above", 0, 0, SIZE_W, 0, BASE + DEPTH, 32'h0, 0, 32'h0, 1);
    dir("size11", 0, 0, 2'b11, 0, BASE, 32'h0, 0, 32'h0, 1);
    dir("sw_last", 0, 1, SIZE_W, 0, BASE + DEPTH - 4, 32'hCAFEF00D, 0, 32'h0, 0);
    dir("lw_last", 0, 0, SIZE_W, 0, BASE + DEPTH - 4, 32'h0, 0, 32'hCAFEF00D, 0);
    dir("lh_last", 0, 0, SIZE_H, 0, BASE + DEPTH - 2, 32'h0, 0, 32'hFFFFCAFE, 0);
    dir("lbu_last", 0, 0, SIZE_B, 1, BASE + DEPTH - 1, 32'h0, 0, 32'h000000CA, 0);
    dir("lw_wrap", 0, 0, SIZE_W, 0, 32'hFFFFFFFC, 32'h0, 0, 32'h0, 1);

    dir("w3_sw", 1, 1, SIZE_W, 0, BASE + 4, 32'h0BADF00D, 5, 32'h0, 0);
    dir("w3_lw", 1, 0, SIZE_W, 0, BASE + 4, 32'h0, 5, 32'h0BADF00D, 0);
    dir("w3_err", 1, 0, SIZE_H, 0, BASE + 5, 32'h0, 5, 32'h0, 1);

    // A store aborted by reset during its wait phase must leave memory untouched
    dir("pre8", 1, 1, SIZE_W, 0, BASE + 8, 32'h12345678, 0, 32'h0, 0);
    @(negedge clock);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_size[1] = SIZE_W;
    req_unsigned[1] = 1'b0;
    req_addr[1] = BASE + 8;
    req_wdata[1] = 32'hDEADBEEF;
    @(posedge clock);
    #1 req_valid[1] = 1'b0;
    @(posedge clock);
    #1;
    chk("wait_ready", 32'(req_ready[1]), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready[1]), 32'd1);
    chk("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("mid_rst_rdata", rsp_rdata[1], 32'd0);
    chk("mid_rst_err", 32'(rsp_err[1]), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    dir("post_rst", 1, 0, SIZE_W, 0, BASE + 8, 32'h0, 0, 32'h12345678, 0);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 50; i++) begin
        a = BASE + 16 + 32'(4 * i);
        xact(d, 1, SIZE_W, 0, a, $urandom, $urandom_range(0, 3), rd, er);
        xact(d, 0, SIZE_W, 0, a, 32'h0, $urandom_range(0, 3), rd, er);
      end
      for (int i = 0; i < 60; i++) begin
        a = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 16 + $urandom_range(0, 199);
        xact(d, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
             $urandom_range(0, 3), rd, er);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
